vga_draw_arbiter: RTL and testbench

- Shares the single VGA adapter plot port between NREQ drawing engines, e.g. fillscreen, circle and reuleaux.
- Each engine uses the start/done handshake and drives its own vga_x/vga_y/vga_colour/vga_plot.
- The arbiter grants one engine at a time, round-robin, and drives that engine's start.
- It muxes the granted engine's plot bus to the adapter, clips off-screen pixels, and returns a one-cycle ack per completed job.

---
 rtl/vga_pkg.sv | 9 +
 rtl/rr_pick.sv | 26 ++
 rtl/vga_draw_arbiter.sv | 82 ++++++++
 tb/tb_vga_draw_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared screen geometry, pixel bus types and arbiter states for the VGA draw slice
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    typedef logic [7:0] vga_x_t;
    typedef logic [6:0] vga_y_t;
    typedef logic [2:0] vga_colour_t;
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select of the first set req bit at or above rr_ptr, wrapping
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   sel,
    output logic            valid
);
    int j;
    always_comb begin
        sel = '0;
        valid = 1'b0;
        j = 0;
        // walk offsets from farthest to nearest so the nearest set bit wins
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            j = (j >= NREQ) ? j - NREQ : j;
            if (req[j]) begin
                sel = IW'(j);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin share of one VGA plot port between NREQ start/done drawing engines,
// with off-screen clipping and a saturating count of clipped plots.
module vga_draw_arbiter #(
    parameter int NREQ = 3,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    output logic [NREQ-1:0]              ack,
    output logic [NREQ-1:0]              eng_start,
    input  logic [NREQ-1:0]              eng_done,
    input  logic [NREQ-1:0][7:0]         eng_x,
    input  logic [NREQ-1:0][6:0]         eng_y,
    input  logic [NREQ-1:0][2:0]         eng_colour,
    input  logic [NREQ-1:0]              eng_plot,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [2:0]                   vga_colour,
    output logic                         vga_plot,
    output logic                         busy,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic [15:0]                  clip_count
);
    import vga_pkg::*;
    localparam int IW = $clog2(NREQ);
    localparam logic [8:0] XLIM = 9'(SCREEN_W);
    localparam logic [7:0] YLIM = 8'(SCREEN_H);
    arb_state_t state;
    logic [IW-1:0] rr_ptr, pick_sel;
    logic pick_valid, run, on_screen, strobe;
    vga_x_t cur_x;
    vga_y_t cur_y;
    vga_colour_t cur_colour;
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .rr_ptr(rr_ptr),
        .sel(pick_sel),
        .valid(pick_valid)
    );
    assign run = state == RUN;
    assign cur_x = eng_x[grant_id];
    assign cur_y = eng_y[grant_id];
    assign cur_colour = eng_colour[grant_id];
    assign strobe = run && eng_plot[grant_id];
    assign on_screen = ({1'b0, cur_x} < XLIM) && ({1'b0, cur_y} < YLIM);
    assign vga_x = run ? cur_x : '0;
    assign vga_y = run ? cur_y : '0;
    assign vga_colour = run ? cur_colour : '0;
    assign vga_plot = strobe && on_screen;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            eng_start <= '0;
            ack <= '0;
            grant_id <= '0;
            rr_ptr <= '0;
            clip_count <= '0;
        end else begin
            ack <= '0;
            if (strobe && !on_screen && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
            case (state)
                IDLE: if (pick_valid) begin
                    grant_id <= pick_sel;
                    eng_start <= NREQ'(1) << pick_sel;
                    state <= RUN;
                end
                RUN: if (eng_done[grant_id]) begin
                    eng_start <= '0;
                    ack <= NREQ'(1) << grant_id;
                    rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    state <= RELEASE;
                end
                RELEASE: if (!eng_done[grant_id]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed checks of grant order, plot muxing, clipping, isolation, reset and sticky done
module tb_vga_draw_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] ack, eng_start;
    logic [2:0] eng_done = '0;
    logic [2:0][7:0] eng_x = '0;
    logic [2:0][6:0] eng_y = '0;
    logic [2:0][2:0] eng_colour = '0;
    logic [2:0] eng_plot = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic vga_plot, busy;
    logic [1:0] grant_id;
    logic [15:0] clip_count;
    int checks = 0;
    int failures = 0;

    vga_draw_arbiter #(.NREQ(3), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .eng_start(eng_start),
        .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
        .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .grant_id(grant_id), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // grants engine g from IDLE, finishes it cleanly and returns to IDLE
    task automatic run_job(input int g);
        tick();
        chk("rr_grant_id", 32'(grant_id), 32'(g));
        chk("rr_start_onehot", 32'(eng_start), 32'(1) << g);
        eng_done[g] = 1'b1;
        tick();
        chk("rr_ack", 32'(ack), 32'(1) << g);
        chk("rr_start_drop", 32'(eng_start), 0);
        eng_done[g] = 1'b0;
        tick();
        chk("rr_idle_busy", 32'(busy), 0);
        chk("rr_idle_start", 32'(eng_start), 0);
    endtask

    initial begin
        #2;
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_clip", 32'(clip_count), 0);
        chk("rst_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_noreq_start", 32'(eng_start), 0);

        // single job on engine 0
        req = 3'b001;
        #1;
        chk("single_start_pre", 32'(eng_start), 0);
        tick();
        chk("single_start", 32'(eng_start), 3'b001);
        chk("single_busy", 32'(busy), 1);
        eng_x[0] = 8'd5; eng_y[0] = 7'd7; eng_colour[0] = 3'b010; eng_plot[0] = 1'b1;
        eng_x[1] = 8'd200; eng_y[1] = 7'd20; eng_plot[1] = 1'b1;
        #1;
        chk("single_vga_x", 32'(vga_x), 5);
        chk("single_vga_y", 32'(vga_y), 7);
        chk("single_vga_colour", 32'(vga_colour), 2);
        chk("single_vga_plot", 32'(vga_plot), 1);
        tick();
        eng_plot[0] = 1'b0;
        #1;
        chk("iso_plot_ignored", 32'(vga_plot), 0);
        chk("iso_x_tracks_grant", 32'(vga_x), 5);
        tick();
        chk("iso_clip_unchanged", 32'(clip_count), 0);

        // clipping boundaries
        eng_plot[0] = 1'b1; eng_x[0] = 8'd160; eng_y[0] = 7'd10;
        #1;
        chk("clip_x160_plot", 32'(vga_plot), 0);
        tick();
        eng_x[0] = 8'd10; eng_y[0] = 7'd120;
        #1;
        chk("clip_y120_plot", 32'(vga_plot), 0);
        tick();
        eng_x[0] = 8'd159; eng_y[0] = 7'd119;
        #1;
        chk("clip_corner_plot", 32'(vga_plot), 1);
        tick();
        eng_plot = '0;
        chk("clip_count", 32'(clip_count), 2);

        req = 3'b000;
        eng_done[0] = 1'b1;
        #1;
        chk("done_ack_pre", 32'(ack), 0);
        tick();
        chk("done_ack", 32'(ack), 3'b001);
        chk("done_start_drop", 32'(eng_start), 0);
        chk("release_busy", 32'(busy), 1);
        chk("release_plot", 32'(vga_plot), 0);
        eng_done[0] = 1'b0;
        tick();
        chk("ack_one_cycle", 32'(ack), 0);
        chk("single_busy_end", 32'(busy), 0);

        // round robin from reset with all requests held
        rst_n = 1'b0;
        req = 3'b111;
        tick();
        rst_n = 1'b1;
        run_job(0);
        run_job(1);
        run_job(2);
        run_job(0);

        // move rr_ptr to 2, then reset during engine 2's run
        req = 3'b010;
        run_job(1);
        req = 3'b100;
        tick();
        chk("mid_grant2", 32'(grant_id), 2);
        chk("mid_start2", 32'(eng_start), 3'b100);
        eng_plot[2] = 1'b1; eng_x[2] = 8'd3; eng_y[2] = 7'd3;
        #1;
        chk("mid_plot_on", 32'(vga_plot), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", 32'(eng_start), 0);
        chk("mid_rst_plot", 32'(vga_plot), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        tick();
        eng_plot = '0;
        rst_n = 1'b1;
        req = 3'b101;
        tick();
        chk("post_rst_ptr0", 32'(grant_id), 0);
        chk("post_rst_start", 32'(eng_start), 3'b001);

        // sticky done on engine 0 with all requests pending
        req = 3'b111;
        eng_done[0] = 1'b1;
        tick();
        chk("sticky_ack", 32'(ack), 3'b001);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("sticky_busy", 32'(busy), 1);
            chk("sticky_no_grant", 32'(eng_start), 0);
        end
        eng_done[0] = 1'b0;
        tick();
        chk("sticky_idle", 32'(busy), 0);
        chk("sticky_idle_start", 32'(eng_start), 0);
        tick();
        chk("sticky_regrant", 32'(eng_start), 3'b010);
        chk("sticky_regrant_id", 32'(grant_id), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
